// File: rtl/aes_enc_round_iter.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Holds the S-box table, the 16-byte sub_byte layer and the round/key-schedule controller.

module sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry a sits at bit 2047-8a, which is simply {~a, 3'b111}.
    assign o_y = SBOX_TBL[{~i_a, 3'b111} -: 8];
endmodule

module sub_byte (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    for (genvar g = 0; g < 16; g++) begin : g_sbox
        sbox u_sbox (.i_a(i_state[8*g +: 8]), .o_y(o_state[8*g +: 8]));
    end
endmodule

module aes_enc_round_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] cipher_text
);
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         r_fsm;
    logic [127:0]   r_state;
    logic [127:0]   r_rk;
    logic [3:0]     r_round;

    logic [127:0]   w_sb;
    logic [127:0]   w_sr;
    logic [127:0]   w_mc;
    logic [127:0]   w_rk_next;
    logic [127:0]   w_round_out;
    logic [31:0]    w_rot;
    logic [31:0]    w_subw;
    logic [31:0]    w_t;
    logic [7:0]     w_rcon;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    sub_byte u_sub_byte (.i_state(r_state), .o_state(w_sb));

    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127 - 8*(4*c + r) -: 8] = w_sb[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
    end

    always_comb begin
        w_mc = '0;
        for (int c = 0; c < 4; c++) begin
            w_mc[127 - 32*c -: 32] = mix_col(w_sr[127 - 32*c -: 32]);
        end
    end

    always_comb begin
        case (r_round)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // Key schedule: SubWord(RotWord(w3)) ^ rcon, then the xor chain across the four words.
    assign w_rot = {r_rk[23:0], r_rk[31:24]};
    for (genvar g = 0; g < 4; g++) begin : g_key_sbox
        sbox u_sbox (.i_a(w_rot[8*g +: 8]), .o_y(w_subw[8*g +: 8]));
    end
    assign w_t = w_subw ^ {w_rcon, 24'h0};
    assign w_rk_next[127:96] = r_rk[127:96] ^ w_t;
    assign w_rk_next[95:64]  = r_rk[95:64]  ^ w_rk_next[127:96];
    assign w_rk_next[63:32]  = r_rk[63:32]  ^ w_rk_next[95:64];
    assign w_rk_next[31:0]   = r_rk[31:0]   ^ w_rk_next[63:32];

    assign w_round_out = ((r_round == 4'd10) ? w_sr : w_mc) ^ w_rk_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_rk        <= '0;
            r_round     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cipher_text <= '0;
        end else begin
            done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_state <= plain_text ^ key;
                        r_rk    <= key;
                        r_round <= 4'd1;
                        busy    <= 1'b1;
                        r_fsm   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_rk <= w_rk_next;
                    if (r_round == 4'd10) begin
                        cipher_text <= w_round_out;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_round     <= '0;
                        r_fsm       <= S_IDLE;
                    end else begin
                        r_state <= w_round_out;
                        r_round <= r_round + 4'd1;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_enc_round_iter.sv
// Bench for aes_enc_round_iter: FIPS-197 vectors plus random blocks checked against
// a byte-array AES-128 model whose S-box is derived from GF(2^8) inversion.

module tb_aes_enc_round_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] cipher_text;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_enc_round_iter dut (
        .clk(clk), .rst(rst), .start(start), .plain_text(plain_text), .key(key),
        .busy(busy), .done(done), .cipher_text(cipher_text)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in, b = b_in, p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] x);
        logic [7:0] e = 8'd254, inv = 8'h01, b, s;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (e[i]) inv = gmul(inv, x);
        end
        b = inv;
        s = inv ^ 8'h63;
        for (int i = 0; i < 4; i++) begin
            b = {b[6:0], b[7]};
            s ^= b;
        end
        return s;
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
        logic [7:0]   st[16], tmp[16], a0, a1, a2, a3, rc;
        logic [31:0]  w[44], t;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m(t[31:24]), sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0])};
                t[31:24] ^= rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = p[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox_m(st[i]);
            tmp = st;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) st[4*c + r] = tmp[4*((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) st[i] ^= w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge: issues a one-cycle start, returns at the following negedge.
    task automatic launch(input logic [127:0] k, input logic [127:0] p);
        key = k; plain_text = p; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Negedges counted until done is seen; -1 if the budget runs out.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; key = rand128(); plain_text = rand128();
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
        n_vec++; if (cipher_text !== 128'h0) begin n_err++; $display("FAIL rst_ct got=%h exp=0", cipher_text); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known(input string nm, input logic [127:0] k, input logic [127:0] p,
                              input logic [127:0] exp_ct);
        int cyc;
        launch(k, p);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy got=%b exp=1", nm, busy); end
        wait_done(cyc);
        n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL %s_latency got=%0d exp=10", nm, cyc); end
        n_vec++; if (cipher_text !== exp_ct) begin n_err++; $display("FAIL %s_ct got=%h exp=%h", nm, cipher_text, exp_ct); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_done got=%b exp=0", nm, busy); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_width got=%b exp=0", nm, done); end
    endtask

    task automatic test_back_to_back();
        int cyc, gap;
        bit held = 1'b1;
        launch(KEY_C, PT_C);
        wait_done(cyc);
        n_vec++; if (cipher_text !== CT_C) begin n_err++; $display("FAIL b2b_ct1 got=%h exp=%h", cipher_text, CT_C); end
        launch(KEY_B, PT_B);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_width got=%b exp=0", done); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%b exp=1", busy); end
        gap = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                gap = k + 1;
                break;
            end
            if (cipher_text !== CT_C) held = 1'b0;
        end
        n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL b2b_hold got=%b exp=1", held); end
        n_vec++; if (gap !== 11) begin n_err++; $display("FAIL b2b_gap got=%0d exp=11", gap); end
        n_vec++; if (cipher_text !== CT_B) begin n_err++; $display("FAIL b2b_ct2 got=%h exp=%h", cipher_text, CT_B); end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [127:0] k0 = rand128(), p0 = rand128(), exp_ct;
        int cyc = -1, extra = 0;
        exp_ct = aes_model(k0, p0);
        key = k0; plain_text = p0; start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
            if (k == 1 || k == 4 || k == 8) start = 1'b0;
            if (k == 3 || k == 7) begin
                start = 1'b1; key = rand128(); plain_text = rand128();
            end
        end
        start = 1'b0;
        n_vec++; if (cyc !== 11) begin n_err++; $display("FAIL ign_latency got=%0d exp=11", cyc); end
        n_vec++; if (cipher_text !== exp_ct) begin n_err++; $display("FAIL ign_ct got=%h exp=%h", cipher_text, exp_ct); end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL ign_extra_done got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid();
        int cyc, spurious = 0;
        launch(KEY_B, PT_B);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", done); end
        n_vec++; if (cipher_text !== 128'h0) begin n_err++; $display("FAIL midrst_ct got=%h exp=0", cipher_text); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) spurious++;
        end
        n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL midrst_no_done got=%0d exp=0", spurious); end
        launch(KEY_B, PT_B);
        wait_done(cyc);
        n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL midrst_latency got=%0d exp=10", cyc); end
        n_vec++; if (cipher_text !== CT_B) begin n_err++; $display("FAIL midrst_ct2 got=%h exp=%h", cipher_text, CT_B); end
        @(negedge clk);
    endtask

    task automatic test_continuous_start();
        logic [127:0] ks[5], ps[5];
        int cyc, extra = 0;
        for (int i = 0; i < 5; i++) begin ks[i] = rand128(); ps[i] = rand128(); end
        key = ks[0]; plain_text = ps[0]; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc = -1;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL cont_done_width blk=%0d got=%b exp=0", i, done); end
                end
                if (done === 1'b1) begin
                    cyc = k;
                    break;
                end
            end
            n_vec++; if (cyc !== 11) begin n_err++; $display("FAIL cont_period blk=%0d got=%0d exp=11", i, cyc); end
            n_vec++; if (cipher_text !== aes_model(ks[i], ps[i])) begin
                n_err++; $display("FAIL cont_ct blk=%0d got=%h exp=%h", i, cipher_text, aes_model(ks[i], ps[i]));
            end
            if (i < 4) begin key = ks[i+1]; plain_text = ps[i+1]; end
            else start = 1'b0;
        end
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        n_vec++; if (extra !== 0) begin n_err++; $display("FAIL cont_tail_done got=%0d exp=0", extra); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_tail_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        logic [127:0] k0, p0, exp_ct;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            k0 = rand128(); p0 = rand128();
            exp_ct = aes_model(k0, p0);
            launch(k0, p0);
            wait_done(cyc);
            n_vec++; if (cyc !== 10) begin n_err++; $display("FAIL rand_latency idx=%0d got=%0d exp=10", i, cyc); end
            n_vec++; if (cipher_text !== exp_ct) begin n_err++; $display("FAIL rand_ct idx=%0d got=%h exp=%h", i, cipher_text, exp_ct); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_known("fips_b", KEY_B, PT_B, CT_B);
        test_known("fips_c1", KEY_C, PT_C, CT_C);
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_continuous_start();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_enc_round_iter.md
# aes_enc_round_iter

Iterative AES-128 encryption core that sits directly downstream of `sub_byte`. It holds the 128-bit cipher state in a register and feeds it through `sub_byte` once per clock. The substituted result then passes through ShiftRows, MixColumns (skipped in the final round) and AddRoundKey. Round keys are expanded on the fly, one per cycle, so one block completes in 10 round cycles after the initial key whitening.

## Interface
- No parameters. The block is fixed to AES-128: 10 rounds, 128-bit key.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to encrypt `plain_text` with `key`; sampled only while idle.
- plain_text  input  128  plaintext block; byte 0 is [127:120], column-major per FIPS-197.
- key  input  128  cipher key, same byte order as `plain_text`.
- busy  output  1  high while a block is in flight.
- done  output  1  one-cycle pulse; `cipher_text` is valid in that cycle.
- cipher_text  output  128  result register; holds its value until the next completion.

## Operation
- State machine has two states.
  - IDLE: busy=0. If start=1 at a clock edge:
    - state_reg <= plain_text ^ key
    - rk_reg <= key
    - round <= 1
    - go to RUN
  - RUN: busy=1. Each edge performs round `round`:
    - Next round key: rk' = expand(rk_reg, rcon[round]).
    - Next state: state_reg <= AddRoundKey(MixColumns(ShiftRows(sub_byte(state_reg))), rk') for rounds 1–9.
    - For round 10, MixColumns is omitted.
    - rk_reg <= rk'
    - round <= round+1
  - Leaving RUN: on the edge executing round 10, the result goes to cipher_text (not state_reg). done <= 1 and the machine returns to IDLE.
- Key expansion per cycle, with words w0..w3 of rk_reg:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, using four `sbox` instances.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- rcon by round 1..10: 01,02,04,08,10,20,40,80,1b,36. The round counter is 4 bits; values 0 and 11–15 are never used in RUN.
- ShiftRows: row r of the column-major state rotates left by r bytes.
- MixColumns: the standard GF(2^8) matrix [2 3 1 1] circulant, with xtime reduction by 8'h1b.
- start while busy=1 is ignored. No queueing, and there is no error indication.
- Inputs are captured only on the accepting edge. Changes to plain_text or key afterwards do not affect the block in flight.
- Reset, including mid-operation:
  - returns to IDLE
  - clears state_reg, rk_reg and round
  - busy=0, done=0, cipher_text=128'h0
  - no done pulse is produced for the aborted block.

## Timing
- Edge E0: start accepted; whitening happens here.
- Edges E1..E10: rounds 1..10. done=1 and cipher_text valid in the cycle after E10.
  - Latency from start edge to done is 10 cycles.
  - Throughput is one block per 11 cycles if start is re-asserted during the done cycle.
- busy rises after E0 and falls after E10, in the same cycle that done rises.
- done lasts exactly one cycle and falls after the next edge.
- start=1 in the done cycle is accepted, because busy is already 0 (back-to-back case). done still deasserts after one cycle, and cipher_text holds the old result until the new block's E10.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, one-cycle start -> done exactly 10 cycles later, cipher_text=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back: C.1 block, then App. B block started in the C.1 done cycle -> two done pulses 11 cycles apart.
  - cipher_text stays 69c4e0d8… until the second done, then becomes 3925841d….
- start pulsed and inputs changed at cycles 3 and 7 while busy -> ignored; the result still equals the original vector and only one done pulse occurs.
- rst asserted at round 5 -> busy, done and cipher_text read 0 immediately and no done appears; a fresh start afterwards gives the correct App. B result.
- Hold start=1 continuously -> one new block every 11 cycles, each with a correct result and a single-cycle done.
